// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: glyph table,
// blank pattern and parameter sanity check.
package display_scanner_pkg;

  typedef logic [0:6] glyph_t;  // index 0 = segment a, active-low

  localparam glyph_t SEG_OFF = 7'b1111111;

  localparam glyph_t GLYPH_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic bit params_ok(int nd, int div, int blank);
    return (nd >= 1) && (nd <= 8) && (div >= 2) && (div <= (1 << 20)) &&
           (blank >= 0) && (blank < div);
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Load-side inputs and display-side outputs of the scanner.
interface display_scanner_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lzs_en;
  logic                    load;
  logic [0:6]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (output value, dp_in, blank_in, lzs_en, load,
                  input  seg, dp, an, frame_start);
  modport slave  (input  value, dp_in, blank_in, lzs_en, load,
                  output seg, dp, an, frame_start);
endinterface

// File: rtl/display_scanner_hex_glyph.sv
// Combinational hex nibble to active-low abcdefg glyph.
module hex_glyph
  import display_scanner_pkg::*;
(
  input  logic [3:0] nib,
  output glyph_t     glyph
);
  assign glyph = GLYPH_TABLE[nib];
endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner with frame-aligned double buffering,
// leading-zero suppression and per-slot anode guard time.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  display_scanner_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (!params_ok(NUM_DIGITS, SCAN_DIV, BLANK_CYCLES)) begin : g_param_err
    $error("display_scanner: parameter out of range");
  end

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
    logic                       lzs;
  } buf_t;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [IW-1:0] msnz;
  buf_t          act, pend, in_buf;
  logic          upd;
  logic          tick, wrap, dark;
  logic [3:0]    cur_nib;
  glyph_t        glyph;

  glyph_t                seg_q;
  logic                  dp_q, fs_q;
  logic [NUM_DIGITS-1:0] an_q;

  assign in_buf = '{nib: bus.value, dp: bus.dp_in, blank: bus.blank_in, lzs: bus.lzs_en};
  assign tick   = (presc == PRESC_LAST);
  assign wrap   = tick && (idx == IDX_LAST);

  // Active buffer only changes at the frame boundary, so one frame never mixes loads;
  // a load coinciding with the boundary bypasses the pending buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      act   <= '0;
      pend  <= '0;
      upd   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      if (bus.load) pend <= in_buf;
      if (wrap) begin
        upd <= 1'b0;
        if (bus.load)  act <= in_buf;
        else if (upd)  act <= pend;
      end else if (bus.load) begin
        upd <= 1'b1;
      end
    end
  end

  // Highest nonzero digit; stays 0 when all digits are zero so digit 0 always shows.
  always_comb begin
    msnz = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (act.nib[k] != 4'h0) msnz = IW'(k);
  end

  assign cur_nib = act.nib[idx];
  assign dark    = act.blank[idx] || (act.lzs && (idx > msnz));

  hex_glyph u_glyph (.nib(cur_nib), .glyph(glyph));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= '1;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= dark ? SEG_OFF : glyph;
      dp_q  <= dark | ~act.dp[idx];
      an_q  <= (presc < BLANK_LIM) ? '1 : ~(NUM_DIGITS'(1) << idx);
      fs_q  <= wrap;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench: a time-based display model pushes the expected outputs each
// cycle, a negedge monitor pops and compares against the DUT.
module tb_display_scanner;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  display_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dpr;
    logic [3:0]  blk;
    logic        lzs;
  } frame_t;

  frame_t      cur, pend;
  bit          pv;
  int          t;
  logic [12:0] expq[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [0:6] glyph_of(logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // What the display shows for cycle tt of the running scan, given the frame content.
  function automatic logic [12:0] expect_out(frame_t f, int tt);
    int slot = (tt / DIV) % ND;
    int ph   = tt % DIV;
    int top  = 0;
    logic       dark, d;
    logic [0:6] s;
    logic [3:0] a, one;
    for (int k = 0; k < ND; k++)
      if (f.v[4*k +: 4] != 4'h0) top = k;
    dark = f.blk[slot] || (f.lzs && slot > top);
    s    = dark ? 7'b1111111 : glyph_of(f.v[4*slot +: 4]);
    d    = dark ? 1'b1 : !f.dpr[slot];
    one  = 4'b0001;
    a    = (ph < BLK) ? 4'b1111 : ~(one << slot);
    return {s, d, a, (tt % FRAME) == FRAME - 1};
  endfunction

  // Reference model: the latest load seen before a frame boundary becomes the next frame.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        expq.push_back(13'b1111111_1_1111_0);
        t   = 0;
        cur = '{v: 16'h0, dpr: 4'h0, blk: 4'h0, lzs: 1'b0};
        pv  = 1'b0;
      end else begin
        expq.push_back(expect_out(cur, t));
        if (bus.load) begin
          pend = '{v: bus.value, dpr: bus.dp_in, blk: bus.blank_in, lzs: bus.lzs_en};
          pv   = 1'b1;
        end
        if ((t % FRAME) == FRAME - 1 && pv) begin
          cur = pend;
          pv  = 1'b0;
        end
        t++;
      end
    end
  end

  initial begin
    logic [12:0] e, a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {bus.seg, bus.dp, bus.an, bus.frame_start};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL display @%0t: got seg=%b dp=%b an=%b fs=%b, expected seg=%b dp=%b an=%b fs=%b",
                   $time, a[12:6], a[5], a[4:1], a[0], e[12:6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic noise();
    bus.value    = 16'($urandom);
    bus.dp_in    = 4'($urandom);
    bus.blank_in = 4'($urandom);
    bus.lzs_en   = 1'($urandom);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      noise();
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d, logic [3:0] b, logic l);
    bus.value = v; bus.dp_in = d; bus.blank_in = b; bus.lzs_en = l;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    noise();
  endtask

  task automatic wait_phase(int ph);
    int guard = 0;
    while ((t % FRAME) != ph && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_phase: got no frame phase %0d within %0d cycles", ph, 2 * FRAME);
    end
  endtask

  function automatic logic [15:0] zero_heavy();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    bus.value = '0; bus.dp_in = '0; bus.blank_in = '0; bus.lzs_en = 1'b0; bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(40);

    wait_phase(10);
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    idle(70);

    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    idle(70);

    wait_phase(5);
    do_load(16'h3333, 4'hF, 4'h0, 1'b0);
    wait_phase(FRAME - 1);
    do_load(16'h8888, 4'h0, 4'h0, 1'b0);
    idle(40);

    do_load(16'($urandom), 4'b0101, 4'b0100, 1'b0);
    idle(70);

    repeat (500) begin
      if ($urandom_range(0, 9) == 0)
        do_load(zero_heavy(), 4'($urandom), 4'($urandom), 1'($urandom));
      else
        idle(1);
    end

    // Reset mid-frame with a load pending, plus a load while held in reset.
    wait_phase(12);
    do_load(16'hBEEF, 4'hF, 4'h0, 1'b0);
    idle(3);
    rst_n = 1'b0;
    do_load(16'h7777, 4'h0, 4'h0, 1'b0);
    idle(1);
    rst_n = 1'b1;
    idle(80);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0)
        do_load(zero_heavy(), 4'($urandom), 4'($urandom), 1'($urandom));
      else
        idle(1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
